jtsdram_bank_resp: RTL
======================

// Module: jtsdram_bank_resp
// PURPOSE
//  Responder end of the SDRAM bank request interface used by jtsdram_bank_rw and the game ports.
//  It accepts rd/wr requests and answers with ack then rdy, serving data from an internal
//  2^MW x 16 RAM. Access latency is jittered and refresh stalls are inserted, so requesters
//  can be stressed in simulation and on the board without a physical SDRAM.
// PARAMETERS
//  AW=22           request address width (16-bit word address)
//  MW=12           log2 of internal RAM depth; addr[MW-1:0] is used, upper bits ignored
//  ACK_DLY=2       cycles from request accept to ack pulse (>=1)
//  RDY_DLY=4       base cycles from ack to rdy pulse (>=1)
//  JIT_W=2         jitter width; extra rdy delay = lfsr[JIT_W-1:0] when jitter=1
//  RFSH_PERIOD=384 cycles between refresh stalls
//  RFSH_LEN=8      length of each refresh stall in cycles
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous, active-low reset
//  rd        in   1   read request, level, held by requester until ack
//  wr        in   1   write request, level, held by requester until ack
//  addr      in   AW  word address, sampled at accept
//  din       in   16  write data, sampled at accept
//  jitter    in   1   1: add LFSR-based extra latency to rdy
//  rfsh_en   in   1   1: insert periodic refresh stalls
//  ack       out  1   one-cycle pulse: request taken, requester may drop rd/wr
//  rdy       out  1   one-cycle pulse: access complete; dout valid for reads
//  dout      out  32  {mem[a+1], mem[a]}, a = sampled addr[MW-1:0], +1 wraps modulo 2^MW
//  proto_err out  1   sticky: rd&wr together, or rd/wr change identity before ack
//  rd_cnt    out  16  completed reads, wraps at 16'hFFFF->0
//  wr_cnt    out  16  completed writes, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE; ack, rdy, proto_err = 0; dout, rd_cnt, wr_cnt = 0;
//   refresh counter = 0; LFSR reloads its seed. RAM contents are not cleared.
//   Reset mid-access aborts the access: no ack or rdy; a pending write is not committed.
//  FSM states: IDLE, ACKW, BUSY, DONE, RFSH.
//   IDLE: if refresh due and rfsh_en=1 -> RFSH. Refresh has priority over a same-cycle request.
//    Else if rd|wr -> latch addr, din, op (wr wins if both are set; set proto_err); dly=ACK_DLY-1; -> ACKW.
//   ACKW: count dly down; at 0 pulse ack, load dly=RDY_DLY-1 (+lfsr[JIT_W-1:0] if jitter) -> BUSY.
//   BUSY: count down; at 0 -> DONE.
//   DONE: for a read, load dout; for a write, commit mem[a]<=din. Pulse rdy; bump rd_cnt/wr_cnt; -> IDLE.
//   RFSH: hold RFSH_LEN cycles; rd/wr are ignored (not acked) -> IDLE.
//  Timing: with jitter=0 and no refresh, ack is seen ACK_DLY cycles after rd first seen high,
//   and rdy is seen RDY_DLY cycles after ack. DONE->IDLE costs 1 cycle.
//  Back-to-back: rd/wr are re-sampled only in IDLE, so a request still high on the rdy cycle
//   is taken one cycle later.
//  Refresh counter counts every cycle, saturates "due" at RFSH_PERIOD, and clears on entering RFSH.
//   A refresh that falls due mid-access waits for IDLE. rfsh_en=0 suppresses RFSH but the counter keeps running.
//  Protocol check: proto_err is set if rd&wr=1 in any cycle, or if the op seen in ACKW differs from
//   the latched op while rd|wr=1. A requester dropping rd/wr before ack is legal (access completes).
//  Read-after-write to the same address returns the new data. Writes update mem[a] only; mem[a+1] is unchanged.
//  dout holds its value between rdy pulses; it is updated only by reads.
// STRUCTURE
//  jtsdram_pkg: state encoding localparams ST_IDLE..ST_RFSH, and the 16-bit LFSR seed.
//  Sub-module: jtsdram_rnd (shared LFSR, adv=1) for jitter. RAM is inferred inline as a
//   dual-read/single-write array.
// TESTING
//  1 Single write 0x1234 @0x10 then read @0x10 (jitter=0, rfsh_en=0): ack at +2, rdy at +4 after ack,
//    dout[15:0]=0x1234.
//  2 Wrap: write 0xAAAA @(2^MW-1) and 0x5555 @0, read @(2^MW-1) -> dout=32'h5555AAAA.
//  3 Refresh: rfsh_en=1, rd held continuously -> no ack for RFSH_LEN cycles at each period;
//    rd_cnt equals the number of rdy pulses.
//  4 Jitter=1, 1000 reads: ack-to-rdy always in [4, 4+3]; no lost or duplicated rdy.
//  5 rd&wr asserted together -> proto_err=1 sticky; the op is executed as a write.
//  6 rst=0 during BUSY of a write -> no rdy; rereading the address returns the old data.
//    Counters and proto_err are 0 after reset.

Source files
------------

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank responder: FSM state codes and LFSR helpers.
package jtsdram_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACKW = 3'd1;
  localparam logic [2:0] ST_BUSY = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_RFSH = 3'd4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Galois LFSR step, x^16+x^14+x^13+x^11 (maximal length)
  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    return r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
  endfunction

endpackage

// File: rtl/jtsdram_rnd.sv
// Free-running 16-bit LFSR used as the jitter source.
module jtsdram_rnd
  import jtsdram_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] rnd
);

  // advance one step per enabled cycle, reload seed on reset
  always_ff @(posedge clk) begin
    if (!rst)     rnd <= LFSR_SEED;
    else if (adv) rnd <= lfsr_next(rnd);
  end

endmodule

// File: rtl/jtsdram_bank_resp.sv
// SDRAM bank responder model: rd/wr -> ack -> rdy with jittered latency,
// periodic refresh stalls and an internal 16-bit RAM.
module jtsdram_bank_resp
  import jtsdram_pkg::*;
#(
  parameter int AW          = 22,
  parameter int MW          = 12,
  parameter int ACK_DLY     = 2,
  parameter int RDY_DLY     = 4,
  parameter int JIT_W       = 2,
  parameter int RFSH_PERIOD = 384,
  parameter int RFSH_LEN    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   din,
  input  logic          jitter,
  input  logic          rfsh_en,
  output logic          ack,
  output logic          rdy,
  output logic [31:0]   dout,
  output logic          proto_err,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt
);

  localparam int DW  = 8;
  localparam int RCW = $clog2(RFSH_PERIOD + 1);

  logic [2:0]     state, nxt;
  logic [DW-1:0]  dly, rdy_ld;
  logic [RCW-1:0] rcnt;
  logic           op_wr;
  logic [MW-1:0]  a;
  logic [15:0]    wdat;
  logic [15:0]    rnd;
  logic           due, dly_z, fin;
  logic [15:0]    mem [0:(1<<MW)-1];
  logic           unused_bits;

  jtsdram_rnd u_rnd (.clk(clk), .rst(rst), .adv(1'b1), .rnd(rnd));

  assign due    = rcnt == RCW'(RFSH_PERIOD);
  assign dly_z  = dly == '0;
  assign fin    = state == ST_BUSY && dly_z;
  assign rdy_ld = DW'(RDY_DLY - 1) + (jitter ? DW'(rnd[JIT_W-1:0]) : '0);
  assign unused_bits = ^{addr[AW-1:MW], rnd[15:JIT_W]};

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  // next-state: refresh beats a same-cycle request, requests only sampled in IDLE
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (due && rfsh_en) nxt = ST_RFSH;
               else if (rd | wr)   nxt = ST_ACKW;
      ST_ACKW: if (dly_z) nxt = ST_BUSY;
      ST_BUSY: if (dly_z) nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      ST_RFSH: if (dly_z) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // rdy is the single DONE cycle
  always_comb begin
    rdy = state == ST_DONE;
  end

  // datapath: latches, delay counter, refresh timer, protocol check, counters.
  // Completion effects land on the edge into DONE so they are visible with rdy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack       <= 1'b0;
      dly       <= '0;
      rcnt      <= '0;
      op_wr     <= 1'b0;
      a         <= '0;
      wdat      <= '0;
      dout      <= '0;
      proto_err <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      ack <= state == ST_ACKW && dly_z;
      if ((rd && wr) || (state == ST_ACKW && (rd | wr) && wr != op_wr))
        proto_err <= 1'b1;
      if (state == ST_IDLE && nxt == ST_RFSH) rcnt <= '0;
      else if (!due)                          rcnt <= rcnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (nxt == ST_RFSH) dly <= DW'(RFSH_LEN - 1);
          else if (rd | wr) begin
            a     <= addr[MW-1:0];
            wdat  <= din;
            op_wr <= wr;
            dly   <= DW'(ACK_DLY - 1);
          end
        end
        ST_ACKW: dly <= dly_z ? rdy_ld : dly - 1'b1;
        ST_BUSY: begin
          if (dly_z) begin
            if (op_wr) wr_cnt <= wr_cnt + 1'b1;
            else begin
              dout   <= {mem[a + MW'(1)], mem[a]};
              rd_cnt <= rd_cnt + 1'b1;
            end
          end else dly <= dly - 1'b1;
        end
        ST_RFSH: if (!dly_z) dly <= dly - 1'b1;
        default: ;
      endcase
    end
  end

  // RAM write port: commit only on a completing write, never under reset
  always_ff @(posedge clk) begin
    if (rst && fin && op_wr) mem[a] <= wdat;
  end

endmodule
